// File: rtl/fir_host_sequencer.sv
// fir_host_sequencer: host-side driver for the FIR accelerator push/pop port set.
// For each upstream sample it pushes TAPS coefficients and then the sample, waits
// for the accelerator's result strobe, pops the result and offers it downstream.
// Optional feature macro: FIR_SEQ_TIMEOUT_EN (bounded WAIT_RESULT with sticky
// timeout_err). Without it WAIT_RESULT waits indefinitely and timeout_err is 0.
module fir_host_sequencer #(
   parameter int unsigned TAPS           = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_enable,
   input  logic                    i_in_valid,
   input  logic [7:0]              i_in_data,
   output logic                    o_in_ready,
   input  logic                    i_cfg_we,
   input  logic [$clog2(TAPS)-1:0] i_cfg_addr,
   input  logic [7:0]              i_cfg_data,
   output logic                    o_push_sample,
   output logic [7:0]              o_new_sample,
   output logic                    o_push_coef,
   output logic [7:0]              o_new_coef,
   output logic                    o_pop_output,
   input  logic [7:0]              i_data_out,
   input  logic                    i_new_output_byte,
   output logic                    o_out_valid,
   output logic [7:0]              o_out_data,
   input  logic                    i_out_ready,
   output logic                    o_busy,
   output logic                    o_timeout_err
);

   localparam int unsigned AW = $clog2(TAPS);
   localparam int unsigned DW = 8;

   // Parameter sanity checks at elaboration
   if (TAPS < 2) begin : g_bad_taps
      $error("fir_host_sequencer: TAPS must be at least 2");
   end
   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("fir_host_sequencer: TIMEOUT_CYCLES must be at least 1");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_PUSH_COEF,
      S_PUSH_SAMPLE,
      S_WAIT_RESULT,
      S_POP,
      S_CAPTURE,
      S_OUTPUT
   } state_t;

   state_t         r_state;
   state_t         w_state_nxt;
   logic [AW-1:0]  r_coef_idx;
   logic [AW-1:0]  w_coef_idx_nxt;
   logic [DW-1:0]  r_sample;
   logic [DW-1:0]  w_sample_nxt;
   logic [DW-1:0]  r_coef [TAPS];

   logic           r_push_coef;
   logic           w_push_coef_nxt;
   logic [DW-1:0]  r_new_coef;
   logic [DW-1:0]  w_new_coef_nxt;
   logic           r_push_sample;
   logic           w_push_sample_nxt;
   logic [DW-1:0]  r_new_sample;
   logic [DW-1:0]  w_new_sample_nxt;
   logic           r_pop_output;
   logic           w_pop_output_nxt;
   logic           r_out_valid;
   logic           w_out_valid_nxt;
   logic [DW-1:0]  r_out_data;
   logic [DW-1:0]  w_out_data_nxt;
   logic           r_busy;
   logic           w_busy_nxt;

   logic           w_accept;
   logic           w_cfg_wr;
   logic [DW-1:0]  w_coef0;
   logic           w_tmo_hit;

   assign w_accept   = (r_state == S_IDLE) && i_enable && i_in_valid;
   assign o_in_ready = (r_state == S_IDLE) && i_enable && !i_reset;
   assign w_cfg_wr   = i_cfg_we && !r_busy;
   // First beat forwards a same-cycle write to index 0 so the new value is pushed
   assign w_coef0    = (w_cfg_wr && (i_cfg_addr == '0)) ? i_cfg_data : r_coef[0];

   // Coefficient bank: writable only while idle
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int i = 0; i < TAPS; i++) begin
            r_coef[i] <= '0;
         end
      end else if (w_cfg_wr) begin
         r_coef[i_cfg_addr] <= i_cfg_data;
      end
   end

`ifdef FIR_SEQ_TIMEOUT_EN
   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CW-1:0] r_tmo_cnt;
   logic          r_timeout_err;

   assign w_tmo_hit = (r_state == S_WAIT_RESULT) && !i_new_output_byte &&
                      (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

   // WAIT_RESULT cycle counter and sticky timeout flag
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_tmo_cnt     <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_state == S_WAIT_RESULT) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
         end else begin
            r_tmo_cnt <= '0;
         end
         if (w_tmo_hit) begin
            r_timeout_err <= 1'b1;
         end
      end
   end

   assign o_timeout_err = r_timeout_err;
`else
   assign w_tmo_hit     = 1'b0;
   assign o_timeout_err = 1'b0;
`endif

   // Next-state and next-output decode; strobes and data default to zero
   always_comb begin
      w_state_nxt       = r_state;
      w_coef_idx_nxt    = r_coef_idx;
      w_sample_nxt      = r_sample;
      w_push_coef_nxt   = 1'b0;
      w_new_coef_nxt    = '0;
      w_push_sample_nxt = 1'b0;
      w_new_sample_nxt  = '0;
      w_pop_output_nxt  = 1'b0;
      w_out_valid_nxt   = r_out_valid;
      w_out_data_nxt    = r_out_data;

      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_sample_nxt    = i_in_data;
               w_coef_idx_nxt  = '0;
               w_push_coef_nxt = 1'b1;
               w_new_coef_nxt  = w_coef0;
               w_state_nxt     = S_PUSH_COEF;
            end
         end
         S_PUSH_COEF: begin
            if (r_coef_idx == AW'(TAPS - 1)) begin
               w_push_sample_nxt = 1'b1;
               w_new_sample_nxt  = r_sample;
               w_state_nxt       = S_PUSH_SAMPLE;
            end else begin
               w_coef_idx_nxt  = r_coef_idx + 1'b1;
               w_push_coef_nxt = 1'b1;
               w_new_coef_nxt  = r_coef[w_coef_idx_nxt];
            end
         end
         S_PUSH_SAMPLE: begin
            w_state_nxt = S_WAIT_RESULT;
         end
         S_WAIT_RESULT: begin
            if (i_new_output_byte) begin
               w_pop_output_nxt = 1'b1;
               w_state_nxt      = S_POP;
            end else if (w_tmo_hit) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_POP: begin
            w_state_nxt = S_CAPTURE;
         end
         S_CAPTURE: begin
            w_out_valid_nxt = 1'b1;
            w_out_data_nxt  = i_data_out;
            w_state_nxt     = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (r_out_valid && i_out_ready) begin
               w_out_valid_nxt = 1'b0;
               w_state_nxt     = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   // State and registered outputs; reset dominates in every state
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state       <= S_IDLE;
         r_coef_idx    <= '0;
         r_sample      <= '0;
         r_push_coef   <= 1'b0;
         r_new_coef    <= '0;
         r_push_sample <= 1'b0;
         r_new_sample  <= '0;
         r_pop_output  <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_data    <= '0;
         r_busy        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_coef_idx    <= w_coef_idx_nxt;
         r_sample      <= w_sample_nxt;
         r_push_coef   <= w_push_coef_nxt;
         r_new_coef    <= w_new_coef_nxt;
         r_push_sample <= w_push_sample_nxt;
         r_new_sample  <= w_new_sample_nxt;
         r_pop_output  <= w_pop_output_nxt;
         r_out_valid   <= w_out_valid_nxt;
         r_out_data    <= w_out_data_nxt;
         r_busy        <= w_busy_nxt;
      end
   end

   assign o_push_coef   = r_push_coef;
   assign o_new_coef    = r_new_coef;
   assign o_push_sample = r_push_sample;
   assign o_new_sample  = r_new_sample;
   assign o_pop_output  = r_pop_output;
   assign o_out_valid   = r_out_valid;
   assign o_out_data    = r_out_data;
   assign o_busy        = r_busy;

endmodule

// File: tb/tb_fir_host_sequencer.sv
// Bench for fir_host_sequencer: a transaction-level model of the host protocol
// (coefficient bank contents, expected per-cycle strobe pattern and result path)
// driven with randomized samples, results, accelerator latencies and backpressure.
module tb_fir_host_sequencer;

   localparam int unsigned TAPS = 4;
   localparam int unsigned TMO  = 16;
   localparam int unsigned AW   = $clog2(TAPS);

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [7:0]    cfg_data;
   logic          push_sample;
   logic [7:0]    new_sample;
   logic          push_coef;
   logic [7:0]    new_coef;
   logic          pop_output;
   logic [7:0]    data_out;
   logic          new_output_byte;
   logic          out_valid;
   logic [7:0]    out_data;
   logic          out_ready;
   logic          busy;
   logic          timeout_err;

   int checks = 0;
   int errors = 0;

   // Model of the coefficient bank as the host should see it
   logic [7:0] m_coef [TAPS];

   always #5 clk = ~clk;

   fir_host_sequencer #(.TAPS(TAPS), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk             (clk),
      .i_reset           (reset),
      .i_enable          (enable),
      .i_in_valid        (in_valid),
      .i_in_data         (in_data),
      .o_in_ready        (in_ready),
      .i_cfg_we          (cfg_we),
      .i_cfg_addr        (cfg_addr),
      .i_cfg_data        (cfg_data),
      .o_push_sample     (push_sample),
      .o_new_sample      (new_sample),
      .o_push_coef       (push_coef),
      .o_new_coef        (new_coef),
      .o_pop_output      (pop_output),
      .i_data_out        (data_out),
      .i_new_output_byte (new_output_byte),
      .o_out_valid       (out_valid),
      .o_out_data        (out_data),
      .i_out_ready       (out_ready),
      .o_busy            (busy),
      .o_timeout_err     (timeout_err)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_coef(input logic [AW-1:0] a, input logic [7:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      m_coef[a] = d;
      step();
      cfg_we = 1'b0;
   endtask

   // One full transaction starting in an IDLE cycle; flags = {push_coef,push_sample,pop,out_valid,busy}
   task automatic run_txn(input logic [7:0] s, input logic [7:0] res, input int wait_cyc,
                          input int hold_cyc, input bit spurious, input bit drop_wr,
                          input bit pre_ready, input bit same_wr, input logic [AW-1:0] same_addr,
                          input logic [7:0] same_data, input bit next_valid, input logic [7:0] next_s);
      logic [4:0] fl;
      in_valid = 1'b1;
      in_data  = s;
      if (same_wr) begin
         cfg_we   = 1'b1;
         cfg_addr = same_addr;
         cfg_data = same_data;
         m_coef[same_addr] = same_data;
      end
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL accept_ready: got %b want 1", in_ready);
      end
      step();
      cfg_we   = 1'b0;
      in_valid = next_valid;
      in_data  = next_valid ? next_s : 8'($urandom);

      for (int k = 0; k < TAPS; k++) begin
         new_output_byte = spurious && (k == 0);
         if (drop_wr && (k == 1)) begin
            cfg_we   = 1'b1;
            cfg_addr = AW'(2);
            cfg_data = 8'hFF;
         end else begin
            cfg_we = 1'b0;
         end
         #1;
         fl = {push_coef, push_sample, pop_output, out_valid, busy};
         checks++;
         if (fl !== 5'b10001 || new_coef !== m_coef[k] || new_sample !== 8'h00 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL coef_beat%0d: flags %b coef %h smp %h rdy %b, want flags 10001 coef %h smp 00 rdy 0",
                     k, fl, new_coef, new_sample, in_ready, m_coef[k]);
         end
         step();
      end
      new_output_byte = 1'b0;
      cfg_we          = 1'b0;

      fl = {push_coef, push_sample, pop_output, out_valid, busy};
      checks++;
      if (fl !== 5'b01001 || new_sample !== s || new_coef !== 8'h00) begin
         errors++;
         $display("FAIL push_sample: flags %b smp %h coef %h, want flags 01001 smp %h coef 00",
                  fl, new_sample, new_coef, s);
      end
      out_ready = pre_ready;
      step();

      for (int i = 0; i < wait_cyc; i++) begin
         fl = {push_coef, push_sample, pop_output, out_valid, busy};
         checks++;
         if (fl !== 5'b00001 || timeout_err !== 1'b0 && wait_cyc < TMO) begin
            errors++;
            $display("FAIL wait%0d: flags %b terr %b, want flags 00001", i, fl, timeout_err);
         end
         step();
      end

      new_output_byte = 1'b1;
      fl = {push_coef, push_sample, pop_output, out_valid, busy};
      checks++;
      if (fl !== 5'b00001) begin
         errors++;
         $display("FAIL strobe_cycle: flags %b want 00001", fl);
      end
      step();
      new_output_byte = 1'b0;

      fl = {push_coef, push_sample, pop_output, out_valid, busy};
      checks++;
      if (fl !== 5'b00101) begin
         errors++;
         $display("FAIL pop: flags %b want 00101", fl);
      end
      step();

      data_out = res;
      fl = {push_coef, push_sample, pop_output, out_valid, busy};
      checks++;
      if (fl !== 5'b00001) begin
         errors++;
         $display("FAIL capture: flags %b want 00001", fl);
      end
      step();
      data_out = 8'($urandom);

      for (int h = 0; h <= hold_cyc; h++) begin
         out_ready = (h == hold_cyc);
         #1;
         fl = {push_coef, push_sample, pop_output, out_valid, busy};
         checks++;
         if (fl !== 5'b00011 || out_data !== res || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL output%0d: flags %b data %h rdy %b, want flags 00011 data %h rdy 0",
                     h, fl, out_data, in_ready, res);
         end
         step();
      end
      out_ready = 1'b0;
      #1;
      fl = {push_coef, push_sample, pop_output, out_valid, busy};
      checks++;
      if (fl !== 5'b00000 || in_ready !== enable) begin
         errors++;
         $display("FAIL after_handshake: flags %b rdy %b, want flags 00000 rdy %b", fl, in_ready, enable);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; in_valid = 1'b1; in_data = 8'h77;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; data_out = '0;
      new_output_byte = 1'b0; out_ready = 1'b0;
      step();
      step();
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      checks++;
      if ({push_coef, push_sample, pop_output, out_valid, busy, timeout_err} !== 6'b0 ||
          new_coef !== 8'h00 || new_sample !== 8'h00 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_outputs: strobes %b coef %h smp %h data %h, want all zero",
                  {push_coef, push_sample, pop_output, out_valid, busy, timeout_err},
                  new_coef, new_sample, out_data);
      end
      reset = 1'b0; in_valid = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL idle_in_ready: got %b want 1", in_ready);
      end
      for (int i = 0; i < TAPS; i++) m_coef[i] = 8'h00;
   endtask

   task automatic test_basic();
      for (int i = 0; i < TAPS; i++) write_coef(AW'(i), 8'(i + 1));
      run_txn(8'h05, 8'h2A, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic test_back_to_back();
      run_txn(8'h11, 8'hC3, 2, 10, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b1, 8'h99);
      run_txn(8'h99, 8'h3C, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic test_busy_write();
      write_coef(AW'(2), 8'h33);
      run_txn(8'h42, 8'h81, 1, 1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 8'h00, 1'b0, 8'h00);
      run_txn(8'h43, 8'h82, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic test_same_cycle_write();
      run_txn(8'hA0, 8'h0F, 2, 0, 1'b0, 1'b0, 1'b1, 1'b1, AW'(0), 8'hE7, 1'b0, 8'h00);
      run_txn(8'hA1, 8'hF0, 0, 2, 1'b1, 1'b0, 1'b1, 1'b1, AW'(TAPS - 1), 8'h5A, 1'b0, 8'h00);
   endtask

   task automatic test_enable();
      enable = 1'b0; in_valid = 1'b1; in_data = 8'h66;
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         if (in_ready !== 1'b0 || busy !== 1'b0 || push_coef !== 1'b0) begin
            errors++;
            $display("FAIL enable_low%0d: rdy %b busy %b pcoef %b, want 0 0 0", i, in_ready, busy, push_coef);
         end
         step();
      end
      enable = 1'b1; in_valid = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [4:0] fl;
      in_valid = 1'b1; in_data = 8'h3D;
      step();
      in_valid = 1'b0;
      step();
      reset = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_ready: got %b want 0", in_ready);
      end
      step();
      reset = 1'b0;
      fl = {push_coef, push_sample, pop_output, out_valid, busy};
      checks++;
      if (fl !== 5'b00000 || new_coef !== 8'h00 || out_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid: flags %b coef %h data %h, want flags 00000 coef 00 data 00",
                  fl, new_coef, out_data);
      end
      for (int i = 0; i < TAPS; i++) m_coef[i] = 8'h00;
      run_txn(8'($urandom), 8'($urandom), 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b0, 8'h00);
   endtask

   task automatic test_timeout();
`ifdef FIR_SEQ_TIMEOUT_EN
      logic [4:0] fl;
      run_txn(8'($urandom), 8'h6E, TMO - 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b0, 8'h00);
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL last_cycle_pulse: terr %b want 0", timeout_err);
      end
      in_valid = 1'b1; in_data = 8'($urandom);
      step();
      in_valid = 1'b0;
      for (int k = 0; k < TAPS + 1; k++) step();
      for (int i = 0; i < TMO; i++) begin
         fl = {push_coef, push_sample, pop_output, out_valid, busy};
         checks++;
         if (fl !== 5'b00001 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL tmo_wait%0d: flags %b terr %b, want 00001 0", i, fl, timeout_err);
         end
         step();
      end
      fl = {push_coef, push_sample, pop_output, out_valid, busy};
      checks++;
      if (fl !== 5'b00000 || timeout_err !== 1'b1 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL tmo_fire: flags %b terr %b rdy %b, want 00000 1 1", fl, timeout_err, in_ready);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL tmo_no_output%0d: valid %b busy %b, want 0 0", i, out_valid, busy);
         end
      end
      run_txn(8'($urandom), 8'($urandom), 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b0, 8'h00);
      checks++;
      if (timeout_err !== 1'b1) begin
         errors++;
         $display("FAIL tmo_sticky: terr %b want 1", timeout_err);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL tmo_reset: terr %b want 0", timeout_err);
      end
      for (int i = 0; i < TAPS; i++) m_coef[i] = 8'h00;
`else
      run_txn(8'($urandom), 8'($urandom), 40, 1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 8'h00, 1'b0, 8'h00);
      checks++;
      if (timeout_err !== 1'b0) begin
         errors++;
         $display("FAIL no_timeout: terr %b want 0", timeout_err);
      end
`endif
   endtask

   task automatic test_random();
      for (int n = 0; n < 20; n++) begin
         for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
            write_coef(AW'($urandom_range(0, TAPS - 1)), 8'($urandom));
         end
         run_txn(8'($urandom), 8'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 4)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), AW'($urandom_range(0, TAPS - 1)), 8'($urandom),
                 1'b0, 8'h00);
         step();
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_busy_write();
      test_same_cycle_write();
      test_enable();
      test_reset_mid();
      test_timeout();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
